// File: rtl/analog_spin_writer_pkg.sv
// Shared types for the analog spin writer: FSM state encoding, the phase
// count type and the zero-to-one clamp applied to every run-time count.
package analog_spin_writer_pkg;

    localparam int CNT_WIDTH = 16;

    typedef logic [CNT_WIDTH-1:0] count_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WWL_HIGH,
        ST_WWL_LOW,
        ST_COMPUTE,
        ST_DONE
    } writer_state_e;

    // A zero-length phase is never allowed; 0 means "one cycle".
    function automatic count_t clamp_count(input count_t c);
        return (c == '0) ? count_t'(1) : c;
    endfunction

    // Value loaded into the phase counter on phase entry.
    function automatic count_t phase_load(input count_t c);
        return clamp_count(c) - count_t'(1);
    endfunction

endpackage

// File: rtl/analog_spin_writer_phase_down_counter.sv
// Loadable down-counter shared by all writer phases; the phase ends in the
// cycle where the counter reads zero.
module analog_spin_writer_phase_down_counter
    import analog_spin_writer_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  count_t load_value_i,
    input  logic   dec_i,
    output logic   is_zero_o
);

    count_t count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - count_t'(1);
        end
    end

    assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/analog_spin_writer.sv
// Transmit side of the digital-to-analog spin interface: latches a spin vector
// onto the write bit lines, pulses the word lines, then waits out the compute window.
module analog_spin_writer
    import analog_spin_writer_pkg::*;
#(
    parameter int NUM_SPIN         = 256,
    parameter int COUNTER_BITWIDTH = CNT_WIDTH,
    parameter int SPIN_WBL_OFFSET  = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        flush_i,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_cycle_per_spin_write_i,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_cycle_per_wwl_high_i,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_cycle_per_wwl_low_i,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_cycle_per_spin_compute_i,
    input  logic [NUM_SPIN-1:0]         cfg_wwl_strobe_i,
    input  logic                        spin_valid_i,
    output logic                        spin_ready_o,
    input  logic [NUM_SPIN-1:0]         spin_i,
    output logic [NUM_SPIN-1:0]         wbl_o,
    output logic [NUM_SPIN-1:0]         wwl_o,
    output logic                        busy_o,
    output logic                        done_o
);

    writer_state_e       state_q;
    logic [NUM_SPIN-1:0] mask_q;
    logic [NUM_SPIN-1:0] spin_rot;
    count_t              high_load_q;
    count_t              low_load_q;
    count_t              compute_load_q;

    logic   accept;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;
    count_t cnt_load_value;

    for (genvar i = 0; i < NUM_SPIN; i++) begin : g_rot
        assign spin_rot[(i + SPIN_WBL_OFFSET) % NUM_SPIN] = spin_i[i];
    end

    // Gated by rst_ni so the handshake stays low while reset is held.
    assign spin_ready_o = rst_ni & en_i & (state_q == ST_IDLE) & ~flush_i;
    assign accept       = spin_valid_i & spin_ready_o;

    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch.
    always_comb begin
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        cnt_load_value = '0;
        if (!flush_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_load       = accept;
                    cnt_load_value = phase_load(cfg_cycle_per_spin_write_i);
                end
                ST_SETUP: begin
                    cnt_load       = cnt_zero;
                    cnt_dec        = ~cnt_zero;
                    cnt_load_value = high_load_q;
                end
                ST_WWL_HIGH: begin
                    cnt_load       = cnt_zero;
                    cnt_dec        = ~cnt_zero;
                    cnt_load_value = low_load_q;
                end
                ST_WWL_LOW: begin
                    cnt_load       = cnt_zero;
                    cnt_dec        = ~cnt_zero;
                    cnt_load_value = compute_load_q;
                end
                ST_COMPUTE: cnt_dec = ~cnt_zero;
                default: ;
            endcase
        end
    end

    analog_spin_writer_phase_down_counter u_phase_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (cnt_load),
        .load_value_i (cnt_load_value),
        .dec_i        (cnt_dec),
        .is_zero_o    (cnt_zero)
    );

    // NOTE: the latched mask and phase lengths are reset along with the
    // outputs; they are plain flops, not a RAM, so reset costs nothing
    // structural and keeps post-reset state deterministic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            wbl_o          <= '0;
            wwl_o          <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            mask_q         <= '0;
            high_load_q    <= '0;
            low_load_q     <= '0;
            compute_load_q <= '0;
        end else if (flush_i) begin
            // wbl_o deliberately keeps its value on abort.
            state_q <= ST_IDLE;
            wwl_o   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q        <= ST_SETUP;
                        busy_o         <= 1'b1;
                        wbl_o          <= spin_rot;
                        mask_q         <= cfg_wwl_strobe_i;
                        high_load_q    <= phase_load(cfg_cycle_per_wwl_high_i);
                        low_load_q     <= phase_load(cfg_cycle_per_wwl_low_i);
                        compute_load_q <= phase_load(cfg_cycle_per_spin_compute_i);
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        state_q <= ST_WWL_HIGH;
                        wwl_o   <= mask_q;
                    end
                end
                ST_WWL_HIGH: begin
                    if (cnt_zero) begin
                        state_q <= ST_WWL_LOW;
                        wwl_o   <= '0;
                    end
                end
                ST_WWL_LOW: begin
                    if (cnt_zero) state_q <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (cnt_zero) begin
                        state_q <= ST_DONE;
                        done_o  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_analog_spin_writer.sv
// Self-checking bench for analog_spin_writer: directed test-plan scenarios plus
// randomized operations against a cycle-offset reference model.
module tb_analog_spin_writer;

    localparam int N   = 256;
    localparam int CW  = 16;
    localparam int OFF = 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic          flush_i;
    logic [CW-1:0] cfg_w;
    logic [CW-1:0] cfg_h;
    logic [CW-1:0] cfg_l;
    logic [CW-1:0] cfg_c;
    logic [N-1:0]  cfg_wwl_strobe_i;
    logic          spin_valid_i;
    logic          spin_ready_o;
    logic [N-1:0]  spin_i;
    logic [N-1:0]  wbl_o;
    logic [N-1:0]  wwl_o;
    logic          busy_o;
    logic          done_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    analog_spin_writer #(
        .NUM_SPIN         (N),
        .COUNTER_BITWIDTH (CW),
        .SPIN_WBL_OFFSET  (OFF)
    ) dut (
        .clk_i                        (clk_i),
        .rst_ni                       (rst_ni),
        .en_i                         (en_i),
        .flush_i                      (flush_i),
        .cfg_cycle_per_spin_write_i   (cfg_w),
        .cfg_cycle_per_wwl_high_i     (cfg_h),
        .cfg_cycle_per_wwl_low_i      (cfg_l),
        .cfg_cycle_per_spin_compute_i (cfg_c),
        .cfg_wwl_strobe_i             (cfg_wwl_strobe_i),
        .spin_valid_i                 (spin_valid_i),
        .spin_ready_o                 (spin_ready_o),
        .spin_i                       (spin_i),
        .wbl_o                        (wbl_o),
        .wwl_o                        (wwl_o),
        .busy_o                       (busy_o),
        .done_o                       (done_o)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Spin i lands on bit line (i+OFF) mod N: a left rotation by OFF.
    function automatic logic [N-1:0] rot(input logic [N-1:0] s);
        return (s << OFF) | (s >> (N - OFF));
    endfunction

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wbl"},   wbl_o, '0);
        check({tag, ".wwl"},   wwl_o, '0);
        check({tag, ".ready"}, N'(spin_ready_o), '0);
        check({tag, ".busy"},  N'(busy_o), '0);
        check({tag, ".done"},  N'(done_o), '0);
    endtask

    // Starts in the accept cycle T (just after a rising edge, DUT idle) and
    // checks every cycle T+k against the phase boundaries W, W+H, W+H+L+C+1.
    // flush_k / rst_k / en_off_k = 0 disables that event; h_new > 0 rewrites
    // the high-width input after accept.
    task automatic run_op(input string tag, input logic [N-1:0] spin, input logic [N-1:0] strobe,
                          input int w, input int h, input int l, input int c,
                          input int flush_k, input int rst_k, input int en_off_k, input int h_new);
        int ew  = eff(w);
        int eh  = eff(h);
        int tot = eff(w) + eff(h) + eff(l) + eff(c) + 1;
        logic [N-1:0] exp_wbl = rot(spin);
        logic [N-1:0] exp_wwl;
        bit flushed;

        spin_i           = spin;
        cfg_wwl_strobe_i = strobe;
        cfg_w            = CW'(w);
        cfg_h            = CW'(h);
        cfg_l            = CW'(l);
        cfg_c            = CW'(c);
        spin_valid_i     = 1'b1;
        @(negedge clk_i);
        check({tag, ".ready_at_accept"}, N'(spin_ready_o), N'(1));
        step();
        spin_valid_i     = 1'b0;
        spin_i           = rand_vec();
        cfg_wwl_strobe_i = rand_vec();
        cfg_w            = CW'($urandom_range(0, 20));
        cfg_h            = (h_new > 0) ? CW'(h_new) : CW'($urandom_range(0, 20));
        cfg_l            = CW'($urandom_range(0, 20));
        cfg_c            = CW'($urandom_range(0, 20));

        for (int k = 1; k <= tot + 1; k++) begin
            flush_i = (k == flush_k);
            if (k == en_off_k) en_i = 1'b0;
            if (k == rst_k) begin
                rst_ni = 1'b0;
                #1;
                check_all_zero({tag, ".async_rst"});
                repeat (2) step();
                rst_ni = 1'b1;
                return;
            end
            @(negedge clk_i);
            flushed = (flush_k > 0) && (k > flush_k);
            exp_wwl = (!flushed && k > ew && k <= ew + eh) ? strobe : '0;
            check($sformatf("%s.k%0d.wbl", tag, k), wbl_o, exp_wbl);
            check($sformatf("%s.k%0d.wwl", tag, k), wwl_o, exp_wwl);
            check($sformatf("%s.k%0d.done", tag, k), N'(done_o), N'(!flushed && k == tot));
            check($sformatf("%s.k%0d.busy", tag, k), N'(busy_o), N'(!flushed && k <= tot));
            check($sformatf("%s.k%0d.ready", tag, k), N'(spin_ready_o),
                  N'(en_i && !flush_i && (flushed || k > tot)));
            step();
            if (flushed) break;
        end
        flush_i = 1'b0;
    endtask

    initial begin
        logic [N-1:0] held_wbl;
        int w, h, l, c, fk;

        rst_ni           = 1'b0;
        en_i             = 1'b1;
        flush_i          = 1'b0;
        spin_valid_i     = 1'b0;
        spin_i           = '0;
        cfg_wwl_strobe_i = '0;
        cfg_w            = '0;
        cfg_h            = '0;
        cfg_l            = '0;
        cfg_c            = '0;

        repeat (2) step();
        check_all_zero("reset");
        rst_ni = 1'b1;
        step();
        @(negedge clk_i);
        check("idle.ready", N'(spin_ready_o), N'(1));
        check("idle.busy",  N'(busy_o), '0);
        step();

        run_op("nominal", {128{2'b10}}, '1, 3, 5, 5, 7, 0, 0, 0, 0);

        run_op("offset", N'(1), N'(16'h000F), 2, 3, 2, 2, 0, 0, 0, 0);
        @(negedge clk_i);
        check("offset.wbl_is_0x2", wbl_o, N'(2));
        step();

        run_op("zero_counts", rand_vec(), rand_vec(), 0, 0, 0, 0, 0, 0, 0, 0);
        run_op("cfg_change", rand_vec(), '1, 3, 5, 5, 7, 0, 0, 0, 9);
        run_op("flush_high", rand_vec(), '1, 3, 5, 5, 7, 6, 0, 0, 0);
        run_op("after_flush", {128{2'b10}}, '1, 3, 5, 5, 7, 0, 0, 0, 0);

        run_op("en_drop", rand_vec(), rand_vec(), 2, 2, 2, 2, 0, 0, 2, 0);
        held_wbl     = wbl_o;
        spin_valid_i = 1'b1;
        spin_i       = rand_vec();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("en_off.ready", N'(spin_ready_o), '0);
            check("en_off.busy",  N'(busy_o), '0);
            check("en_off.wwl",   wwl_o, '0);
            check("en_off.done",  N'(done_o), '0);
            check("en_off.wbl",   wbl_o, held_wbl);
            step();
        end
        spin_valid_i = 1'b0;
        en_i         = 1'b1;

        run_op("rst_compute", rand_vec(), '1, 3, 5, 5, 7, 0, 16, 0, 0);

        for (int r = 0; r < 8; r++) begin
            w  = $urandom_range(0, 5);
            h  = $urandom_range(0, 5);
            l  = $urandom_range(0, 5);
            c  = $urandom_range(0, 5);
            fk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, eff(w) + eff(h) + eff(l) + eff(c) + 1) : 0;
            run_op($sformatf("rand%0d", r), rand_vec(), rand_vec(), w, h, l, c, fk, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
